// File: rtl/bus_dev_port.sv
// Device-side bus endpoint: show-ahead TX FIFO toward the arbiter, RX FIFO from the bus.
// Define BUS_DEV_ADDR_FILTER_EN to drop and count pushes not addressed to this id or broadcast.
module bus_dev_port #(
    parameter int          pckg_sz   = 16,
    parameter int          fifo_size = 8,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               tx_ovf,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_vld,
    output logic [7:0]         rx_drop_cnt
);

    localparam int aw = (fifo_size > 1) ? $clog2(fifo_size) : 1;
    localparam logic [aw:0] full_cnt = (aw + 1)'(fifo_size);

`ifdef BUS_DEV_ADDR_FILTER_EN
    localparam bit addr_filter = 1'b1;
`else
    localparam bit addr_filter = 1'b0;
`endif

    logic [pckg_sz-1:0] tx_mem [fifo_size];
    logic [aw-1:0]      tx_wptr;
    logic [aw-1:0]      tx_rptr;
    logic [aw:0]        tx_count;
    logic               tx_do_pop;
    logic               tx_do_wr;

    assign pndng     = (tx_count != '0);
    assign tx_full   = (tx_count == full_cnt);
    assign tx_do_pop = pop && pndng;
    // A write into a full FIFO still fits when the head leaves on the same edge.
    assign tx_do_wr  = tx_wr && (!tx_full || tx_do_pop);
    assign D_pop     = pndng ? tx_mem[tx_rptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            tx_ovf   <= 1'b0;
        end else begin
            if (tx_do_wr)
                tx_wptr <= tx_wptr + 1'b1;
            if (tx_do_pop)
                tx_rptr <= tx_rptr + 1'b1;
            case ({tx_do_wr, tx_do_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
            tx_ovf <= tx_wr && !tx_do_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_do_wr)
            tx_mem[tx_wptr] <= tx_data;
    end

    logic [pckg_sz-1:0] rx_mem [fifo_size];
    logic [aw-1:0]      rx_wptr;
    logic [aw-1:0]      rx_rptr;
    logic [aw:0]        rx_count;
    logic               rx_full;
    logic               rx_do_rd;
    logic               addr_hit;
    logic               rx_qual;
    logic               rx_accept;
    logic               rx_drop;

    assign rx_vld    = (rx_count != '0);
    assign rx_full   = (rx_count == full_cnt);
    assign rx_do_rd  = rx_rd && rx_vld;
    assign addr_hit  = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);
    assign rx_qual   = push && (addr_hit || !addr_filter);
    assign rx_accept = rx_qual && (!rx_full || rx_do_rd);
    // Misroutes (filter build) and full-FIFO overruns both land here.
    assign rx_drop   = push && !rx_accept;
    assign rx_data   = rx_vld ? rx_mem[rx_rptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr     <= '0;
            rx_rptr     <= '0;
            rx_count    <= '0;
            rx_drop_cnt <= 8'd0;
        end else begin
            if (rx_accept)
                rx_wptr <= rx_wptr + 1'b1;
            if (rx_do_rd)
                rx_rptr <= rx_rptr + 1'b1;
            case ({rx_accept, rx_do_rd})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
            if (rx_drop && (rx_drop_cnt != 8'hFF))
                rx_drop_cnt <= rx_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_accept)
            rx_mem[rx_wptr] <= D_push;
    end

endmodule

// File: tb/tb_bus_dev_port.sv
// Scoreboard bench for bus_dev_port (id=3); follows BUS_DEV_ADDR_FILTER_EN like the DUT.
module tb_bus_dev_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_wr = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_full;
    logic        tx_ovf;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop = 1'b0;
    logic        push = 1'b0;
    logic [15:0] D_push = '0;
    logic        rx_rd = 1'b0;
    logic [15:0] rx_data;
    logic        rx_vld;
    logic [7:0]  rx_drop_cnt;

    logic [15:0] txq [$];
    logic [15:0] rxq [$];
    int vectors = 0;
    int miscompares = 0;

    bus_dev_port #(
        .pckg_sz(16), .fifo_size(8), .id(8'd3), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_ovf(tx_ovf),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .rx_rd(rx_rd), .rx_data(rx_data),
        .rx_vld(rx_vld), .rx_drop_cnt(rx_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Retired packets are checked against the expected queues at mid-cycle.
    always @(negedge clk) begin
        if (!reset && pop && pndng) begin
            if (txq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL tx_unexpected: got %h, expected no packet", D_pop);
            end else
                check_output("tx_order", D_pop, txq.pop_front());
        end
        if (!reset && rx_rd && rx_vld) begin
            if (rxq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL rx_unexpected: got %h, expected no packet", rx_data);
            end else
                check_output("rx_order", rx_data, rxq.pop_front());
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        txq.delete();
        rxq.delete();
        check_output("rst_pndng", 16'(pndng), 16'd0);
        check_output("rst_tx_full", 16'(tx_full), 16'd0);
        check_output("rst_tx_ovf", 16'(tx_ovf), 16'd0);
        check_output("rst_rx_vld", 16'(rx_vld), 16'd0);
        check_output("rst_drop_cnt", 16'(rx_drop_cnt), 16'd0);
        check_output("rst_D_pop", D_pop, 16'd0);
        check_output("rst_rx_data", rx_data, 16'd0);
        step();
        reset = 1'b0;
    endtask

    task automatic drain_tx();
        pop = 1'b1;
        for (int i = 0; i < 20 && pndng; i++)
            step();
        pop = 1'b0;
        check_output("tx_drained_pndng", 16'(pndng), 16'd0);
        check_output("tx_drained_queue", 16'(txq.size()), 16'd0);
    endtask

    task automatic drain_rx();
        rx_rd = 1'b1;
        for (int i = 0; i < 20 && rx_vld; i++)
            step();
        rx_rd = 1'b0;
        check_output("rx_drained_vld", 16'(rx_vld), 16'd0);
        check_output("rx_drained_queue", 16'(rxq.size()), 16'd0);
    endtask

    task automatic apply_stimulus_tx(input logic [15:0] data, input logic with_pop);
        tx_wr = 1'b1;
        tx_data = data;
        pop = with_pop;
        step();
        tx_wr = 1'b0;
        pop = 1'b0;
    endtask

    task automatic apply_stimulus_rx(input logic [15:0] data);
        push = 1'b1;
        D_push = data;
        step();
        push = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] e;

        #2;
        check_output("init_pndng", 16'(pndng), 16'd0);
        check_output("init_rx_vld", 16'(rx_vld), 16'd0);
        check_output("init_D_pop", D_pop, 16'd0);
        step();
        step();
        reset = 1'b0;

        // Basic TX write/pop ordering.
        txq.push_back(16'h0311);
        apply_stimulus_tx(16'h0311, 1'b0);
        check_output("tx_first_pndng", 16'(pndng), 16'd1);
        check_output("tx_first_head", D_pop, 16'h0311);
        txq.push_back(16'h0522);
        apply_stimulus_tx(16'h0522, 1'b0);
        txq.push_back(16'h0733);
        apply_stimulus_tx(16'h0733, 1'b0);
        pop = 1'b1; step(); pop = 1'b0;
        check_output("tx_head_after_pop1", D_pop, 16'h0522);
        pop = 1'b1; step(); pop = 1'b0;
        check_output("tx_head_after_pop2", D_pop, 16'h0733);
        pop = 1'b1; step(); pop = 1'b0;
        check_output("tx_empty_after_pop3", 16'(pndng), 16'd0);
        pop = 1'b1; step(); pop = 1'b0;
        check_output("tx_pop_empty_ignored", 16'(pndng), 16'd0);

        // TX full, overflow drop, and write-with-pop at full.
        for (int i = 0; i < 8; i++) begin
            d = 16'h1000 + 16'(i);
            txq.push_back(d);
            apply_stimulus_tx(d, 1'b0);
        end
        check_output("tx_full_at_8", 16'(tx_full), 16'd1);
        apply_stimulus_tx(16'hDEAD, 1'b0);
        check_output("tx_ovf_pulse", 16'(tx_ovf), 16'd1);
        check_output("tx_ovf_head_kept", D_pop, 16'h1000);
        step();
        check_output("tx_ovf_cleared", 16'(tx_ovf), 16'd0);
        txq.push_back(16'hBEEF);
        apply_stimulus_tx(16'hBEEF, 1'b1);
        check_output("tx_full_wr_pop", 16'(tx_full), 16'd1);
        check_output("tx_no_ovf_wr_pop", 16'(tx_ovf), 16'd0);
        check_output("tx_head_wr_pop", D_pop, 16'h1001);
        drain_tx();

        // RX ordering and destination handling.
        rxq.push_back(16'h03AB);
        apply_stimulus_rx(16'h03AB);
        check_output("rx_first_vld", 16'(rx_vld), 16'd1);
        check_output("rx_first_head", rx_data, 16'h03AB);
        rxq.push_back(16'hFFCD);
        apply_stimulus_rx(16'hFFCD);
`ifndef BUS_DEV_ADDR_FILTER_EN
        rxq.push_back(16'h04EE);
`endif
        apply_stimulus_rx(16'h04EE);
`ifdef BUS_DEV_ADDR_FILTER_EN
        check_output("rx_misroute_drop", 16'(rx_drop_cnt), 16'd1);
`else
        check_output("rx_misroute_drop", 16'(rx_drop_cnt), 16'd0);
`endif
        drain_rx();

        // RX full drops and saturation.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            d = 16'h0300 + 16'(i);
            rxq.push_back(d);
            apply_stimulus_rx(d);
        end
        check_output("rx_full_vld", 16'(rx_vld), 16'd1);
        check_output("rx_full_no_drop", 16'(rx_drop_cnt), 16'd0);
        apply_stimulus_rx(16'h0399);
        check_output("rx_full_drop1", 16'(rx_drop_cnt), 16'd1);
        push = 1'b1;
        for (int i = 0; i < 100; i++) begin
            D_push = 16'hFF00 + 16'(i);
            step();
        end
        check_output("rx_drop_101", 16'(rx_drop_cnt), 16'h0065);
        for (int i = 0; i < 200; i++) begin
            D_push = 16'h0300 + 16'(i);
            step();
        end
        push = 1'b0;
        check_output("rx_drop_saturated", 16'(rx_drop_cnt), 16'h00FF);
        check_output("rx_full_head", rx_data, 16'h0300);
        drain_rx();

        // Reset with traffic queued in both directions.
        for (int i = 0; i < 5; i++) begin
            tx_wr = 1'b1;
            tx_data = 16'h2000 + 16'(i);
            push = (i < 4);
            D_push = 16'h0340 + 16'(i);
            step();
        end
        tx_wr = 1'b0;
        push = 1'b0;
        apply_reset();
        txq.push_back(16'h0555);
        apply_stimulus_tx(16'h0555, 1'b0);
        check_output("post_rst_pndng", 16'(pndng), 16'd1);
        check_output("post_rst_head", D_pop, 16'h0555);

        // All four strobes every cycle with random data.
        for (int i = 0; i < 100; i++) begin
            d = 16'($urandom);
            e = {(($urandom % 2) == 0) ? 8'h03 : 8'hFF, 8'($urandom)};
            tx_wr = 1'b1; tx_data = d; pop = 1'b1;
            push = 1'b1; D_push = e; rx_rd = 1'b1;
            txq.push_back(d);
            rxq.push_back(e);
            step();
            check_output("mix_tx_ovf", 16'(tx_ovf), 16'd0);
            check_output("mix_drop_cnt", 16'(rx_drop_cnt), 16'd0);
        end
        tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
        drain_tx();
        drain_rx();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
